// File: rtl/key_filter_pkg.sv
// key_filter_pkg: shared state encodings, width helper and next-state function for the key debouncer.
//   No ports; imported by key_filter_ch.
package key_filter_pkg;

    typedef enum logic [3:0] {
        IDLE    = 4'b0001,
        FILTER0 = 4'b0010,
        DOWN    = 4'b0100,
        FILTER1 = 4'b1000
    } state_t;

    // Counter width that never collapses to zero bits (e.g. a disabled hold timer).
    function automatic int cnt_width(input longint n);
        return n < 2 ? 1 : $clog2(n);
    endfunction

    // Any edge beats the terminal count; a press edge inside FILTER1 is a bounce back to DOWN.
    function automatic state_t next_state(input state_t s, input logic pe, input logic re, input logic tc);
        case (s)
            IDLE:    return pe ? FILTER0 : IDLE;
            FILTER0: return re ? IDLE : (tc && !pe) ? DOWN : FILTER0;
            DOWN:    return re ? FILTER1 : DOWN;
            FILTER1: return pe ? DOWN : (tc && !re) ? IDLE : FILTER1;
            default: return IDLE;
        endcase
    endfunction

endpackage

// File: rtl/key_filter_ch.sv
// key_filter_ch: one debounced key channel (synchroniser, edge detect, debounce FSM, hold timer).
//   clk         system clock
//   rst         asynchronous active-low reset
//   key_in      raw key pin, asynchronous to clk
//   key_press   1-cycle pulse on debounced press
//   key_release 1-cycle pulse on debounced release
//   key_long    1-cycle pulse once per press after LONG_MAX cycles held
//   key_state   debounced level, 1 = pressed
module key_filter_ch
    import key_filter_pkg::*;
#(
    parameter int CNT_MAX    = 1_000_000,
    parameter int LONG_MAX   = 50_000_000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic key_press,
    output logic key_release,
    output logic key_long,
    output logic key_state
);

    localparam int CW = cnt_width(CNT_MAX);
    localparam int HW = cnt_width(LONG_MAX + 1);
    localparam logic [CW-1:0] CNT_TOP   = CW'(CNT_MAX - 1);
    localparam logic [HW-1:0] HOLD_SAT  = HW'(LONG_MAX);
    localparam logic [HW-1:0] HOLD_FIRE = HW'(LONG_MAX - 1);
    localparam bit LONG_EN = LONG_MAX != 0;

    logic r1, r2, pe, re;
    logic press_edge, rel_edge, enter_down, leave_up;
    logic [CW-1:0] cnt;
    logic [HW-1:0] hold, hold_n;
    state_t state, state_n;

    // p = 1 means pressed regardless of pin polarity
    assign press_edge = r1 & ~r2;
    assign rel_edge   = ~r1 & r2;
    assign state_n    = next_state(state, pe, re, cnt == CNT_TOP);
    assign enter_down = state == FILTER0 && state_n == DOWN;
    assign leave_up   = state == FILTER1 && state_n == IDLE;
    assign hold_n     = enter_down ? '0 :
                        (state inside {DOWN, FILTER1}) && hold != HOLD_SAT ? hold + 1'b1 : hold;

    // Edge pulses are registered once before the FSM, giving 2 sync + 1 edge + CNT_MAX latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r1          <= 1'b0;
            r2          <= 1'b0;
            pe          <= 1'b0;
            re          <= 1'b0;
            state       <= IDLE;
            cnt         <= '0;
            hold        <= '0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
            key_state   <= 1'b0;
        end else begin
            r1          <= key_in ^ ACTIVE_LOW;
            r2          <= r1;
            pe          <= press_edge;
            re          <= rel_edge;
            state       <= state_n;
            cnt         <= (pe || re || state_n != state || !(state inside {FILTER0, FILTER1})) ? '0 : cnt + 1'b1;
            hold        <= hold_n;
            key_press   <= enter_down;
            key_release <= leave_up;
            key_state   <= state_n inside {DOWN, FILTER1};
            // Fires only on the cycle hold arrives at LONG_MAX-1, and never on the way out to IDLE.
            key_long    <= LONG_EN && state_n != IDLE && hold_n == HOLD_FIRE && (hold_n != hold || enter_down);
        end
    end

endmodule

// File: rtl/key_filter_multi.sv
// key_filter_multi: KEY_NUM independent push-button debouncers.
//   clk         system clock
//   rst         asynchronous active-low reset
//   key_in      raw key pins, asynchronous to clk
//   key_press   per-channel 1-cycle press pulse
//   key_release per-channel 1-cycle release pulse
//   key_long    per-channel 1-cycle long-press pulse
//   key_state   per-channel debounced level, 1 = pressed
module key_filter_multi #(
    parameter int KEY_NUM    = 4,
    parameter int CNT_MAX    = 1_000_000,
    parameter int LONG_MAX   = 50_000_000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [KEY_NUM-1:0] key_in,
    output logic [KEY_NUM-1:0] key_press,
    output logic [KEY_NUM-1:0] key_release,
    output logic [KEY_NUM-1:0] key_long,
    output logic [KEY_NUM-1:0] key_state
);

    for (genvar i = 0; i < KEY_NUM; i++) begin : g_ch
        key_filter_ch #(
            .CNT_MAX   (CNT_MAX),
            .LONG_MAX  (LONG_MAX),
            .ACTIVE_LOW(ACTIVE_LOW)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .key_in     (key_in[i]),
            .key_press  (key_press[i]),
            .key_release(key_release[i]),
            .key_long   (key_long[i]),
            .key_state  (key_state[i])
        );
    end

endmodule

// File: doc/key_filter_multi.md
Name: key_filter_multi

Overview:
Parametrised multi-channel push-button debouncer, the successor to the single-key filter. Each of KEY_NUM raw, asynchronous key inputs is synchronised and debounced by its own edge-driven 4-state FSM. Each channel produces press, release and long-press pulses plus a debounced level. The block sits between board key pins and UI/control logic. Channels are fully independent.

Parameters:
KEY_NUM, 4, number of key channels (>=1)
CNT_MAX, 1_000_000, debounce window in clk cycles (20 ms at 50 MHz); >=2
LONG_MAX, 50_000_000, hold time in clk cycles before key_long fires (1 s at 50 MHz); 0 disables long-press
ACTIVE_LOW, 1, 1: pressed = input low; 0: pressed = input high

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
key_in  in  KEY_NUM  raw key pins, asynchronous to clk
key_press  out  KEY_NUM  1-cycle pulse per channel on debounced press
key_release  out  KEY_NUM  1-cycle pulse per channel on debounced release
key_long  out  KEY_NUM  1-cycle pulse once per press when held LONG_MAX cycles
key_state  out  KEY_NUM  debounced level, 1 = pressed

Behaviour:
- Reset: rst is asynchronous, active-low; clock is clk. All outputs reset to 0, FSMs to IDLE, counters to 0. Synchroniser flops reset to the released level, so reset never causes a spurious edge.
- Per channel: 2-flop synchroniser (r1, r2). Input is normalised so that p=1 means pressed. press_edge = p_r1 & !p_r2; rel_edge = !p_r1 & p_r2.
- Debounce counter cnt ($clog2(CNT_MAX) bits): cleared on every edge and on every state change. Increments each cycle in FILTER0/FILTER1. Held at 0 in IDLE/DOWN.
- FSM (one-hot, 4 states):
  - IDLE: press_edge -> FILTER0.
  - FILTER0: rel_edge -> IDLE, with no pulse. cnt==CNT_MAX-1 and no edge -> DOWN.
  - DOWN: rel_edge -> FILTER1.
  - FILTER1: press_edge -> DOWN (bounce; no pulse, hold timer continues). cnt==CNT_MAX-1 and no edge -> IDLE.
  - Illegal encoding -> IDLE.
  - Edge and terminal count in the same cycle: the edge wins, and the terminal count is ignored.
- Outputs are registered.
  - key_press is high for exactly the first cycle the FSM is in DOWN after FILTER0.
  - key_release is high for exactly the first cycle in IDLE after FILTER1.
  - key_state is 1 in DOWN and FILTER1, 0 otherwise.
- Latency: a clean press is reported CNT_MAX+3 cycles after the key_in transition (2 sync + 1 edge + CNT_MAX count).
- Hold counter hold ($clog2(LONG_MAX+1) bits):
  - Cleared on FILTER0->DOWN.
  - Increments in DOWN and FILTER1; saturates at LONG_MAX.
  - key_long pulses in the single cycle hold reaches LONG_MAX-1.
  - Fires at most once per press.
  - Never fires if LONG_MAX==0.
  - Never fires after leaving to IDLE.
- Bounce longer than CNT_MAX is treated as a genuine transition, by design.
- Channels never interact. Simultaneous events on different channels are each reported in their own bit in the same cycle.
- Reset asserted mid-debounce or mid-hold aborts the operation. After release of reset there are no pulses until a fresh press.

Decomposition:
- Package key_filter_pkg: state encodings IDLE/FILTER0/DOWN/FILTER1 (4'b0001/0010/0100/1000), and a clog2-based width function for cnt and hold.
- Sub-module key_filter_ch: one channel containing the synchroniser, FSM, both counters and the 4 output bits. key_filter_multi is a generate loop over KEY_NUM instances.

Test Plan (CNT_MAX=8, LONG_MAX=40, KEY_NUM=4, ACTIVE_LOW=1):
- Clean press: key_in[0] 1->0, held 60 cycles -> key_press[0] pulses at cycle 11 after the transition. key_state[0]=1 from then on. key_long[0] pulses once, 39 cycles after key_press. Other bits stay 0.
- Glitch: key_in[1] low for 5 cycles, then high -> no pulses; key_state[1] stays 0; FSM returns to IDLE.
- Release bounce: pressed key, then 3 toggles 2 cycles apart, then stable high -> exactly one key_release, 11 cycles after the last edge. key_state stays 1 until that pulse. No extra key_press.
- Short press: press held 20 cycles, then release -> one key_press and one key_release; key_long never pulses.
- Parallel: key_in[2] and key_in[3] pressed in the same cycle -> key_press[2] and key_press[3] pulse in the same cycle.
- Reset: rst low during FILTER0 of ch0 and during hold of ch1 -> all outputs 0 immediately. After rst high with keys released, no pulses for 100 cycles.
